// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and the RX FIFO entry layout.
// Also intended for the parametrised transmitter.
package uart_pkg;

    localparam int PAR_NONE      = 0;
    localparam int PAR_EVEN      = 1;
    localparam int PAR_ODD       = 2;
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_BRKWAIT
    } rx_state_t;

    typedef struct packed {
        logic                     brk;
        logic                     perr;
        logic                     ferr;
        logic [MAX_DATA_BITS-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered head output (no fall-through).
// A push that finds the FIFO full is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST_X,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr, rptr_n;
    logic             do_push, do_pop;

    assign count   = wptr - rptr;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rptr_n  = rptr + (AW+1)'(do_pop);

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    // The head register takes the incoming word directly when it lands in the head slot.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            wptr  <= '0;
            rptr  <= '0;
            rdata <= '0;
        end else begin
            wptr <= wptr + (AW+1)'(do_push);
            rptr <= rptr_n;
            if (do_push && (wptr == rptr_n))
                rdata <= wdata;
            else if (do_pop)
                rdata <= mem[rptr_n[AW-1:0]];
        end
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// UART receiver: 2-flop synchroniser, 3-sample majority voter, frame FSM with error/break
// tagging, feeding a receive FIFO with a valid/ready pop port and a sticky overrun flag.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          CLK,
    input  logic                          RST_X,
    input  logic                          RXD,
    output logic [DATA_BITS-1:0]          RD_DATA,
    output logic                          RD_FERR,
    output logic                          RD_PERR,
    output logic                          RD_BRK,
    output logic                          RD_VALID,
    input  logic                          RD_READY,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT,
    output logic                          OVERRUN,
    input  logic                          OVR_CLR
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_HM1  = CW'(H - 1);
    localparam logic [CW-1:0] C_H    = CW'(H);
    localparam logic [CW-1:0] C_HP1  = CW'(H + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    rx_state_t            state, state_n;
    logic                 sync1, rxs, rxs_d;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [1:0]           smp;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, ferr, stop0;
    logic                 mid, wrap, vote, complete;
    logic                 ferr_fin, stop0_fin, par_exp, perr_fin, brk_fin;
    rx_entry_t            entry_n, entry_q, rd_entry;
    logic                 push_q, pop, full, empty, ovr_set;
    logic                 unused_rd;

    assign mid  = (cnt == C_HP1);
    assign wrap = (cnt == C_LAST);
    assign vote = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);

    // Completion values fold in the stop sample taken this very cycle.
    assign ferr_fin  = ferr | ~vote;
    assign stop0_fin = (bit_idx == '0) ? vote : stop0;
    assign par_exp   = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;
    assign perr_fin  = (PARITY != PAR_NONE) && (par_bit != par_exp);
    assign brk_fin   = (shreg == '0) && ((PARITY == PAR_NONE) || !par_bit) && !stop0_fin;

    always_comb begin
        entry_n      = '0;
        entry_n.brk  = brk_fin;
        entry_n.perr = perr_fin & ~brk_fin;
        entry_n.ferr = ferr_fin | brk_fin;
        entry_n.data[DATA_BITS-1:0] = shreg;
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        complete = 1'b0;
        case (state)
            ST_IDLE:    if (rxs_d && !rxs) state_n = ST_START;
            ST_START: begin
                if (mid && vote)  state_n = ST_IDLE;
                else if (wrap)    state_n = ST_DATA;
            end
            ST_DATA:    if (wrap && bit_idx == LAST_DATA)
                            state_n = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            ST_PAR:     if (wrap) state_n = ST_STOP;
            ST_STOP: begin
                if (mid && bit_idx == LAST_STOP) begin
                    complete = 1'b1;
                    state_n  = brk_fin ? ST_BRKWAIT : ST_IDLE;
                end
            end
            ST_BRKWAIT: if (rxs) state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            sync1   <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            smp     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            ferr    <= 1'b0;
            stop0   <= 1'b1;
            push_q  <= 1'b0;
            entry_q <= '0;
            OVERRUN <= 1'b0;
        end else begin
            sync1 <= RXD;
            rxs   <= sync1;
            rxs_d <= rxs;

            // Counter restarts at 0 on the first START cycle and whenever the frame ends.
            if (state == ST_IDLE || state == ST_BRKWAIT ||
                state_n == ST_IDLE || state_n == ST_BRKWAIT)
                cnt <= '0;
            else
                cnt <= wrap ? '0 : cnt + 1'b1;

            if (state_n != state) bit_idx <= '0;
            else if (wrap)        bit_idx <= bit_idx + 1'b1;

            if (cnt == C_HM1) smp[0] <= rxs;
            if (cnt == C_H)   smp[1] <= rxs;

            if (state == ST_IDLE) begin
                ferr    <= 1'b0;
                par_bit <= 1'b0;
                stop0   <= 1'b1;
            end else if (mid) begin
                case (state)
                    ST_DATA: shreg   <= {vote, shreg[DATA_BITS-1:1]};
                    ST_PAR:  par_bit <= vote;
                    ST_STOP: begin
                        if (!vote)           ferr  <= 1'b1;
                        if (bit_idx == '0)   stop0 <= vote;
                    end
                    default: ;
                endcase
            end

            push_q <= complete;
            if (complete) entry_q <= entry_n;

            if (ovr_set)      OVERRUN <= 1'b1;
            else if (OVR_CLR) OVERRUN <= 1'b0;
        end
    end

    assign pop     = RD_VALID & RD_READY;
    assign ovr_set = push_q & full & ~pop;

    uart_sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST_X (RST_X),
        .push  (push_q),
        .wdata (entry_q),
        .pop   (pop),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty),
        .count (COUNT)
    );

    assign RD_VALID  = ~empty;
    assign RD_DATA   = rd_entry.data[DATA_BITS-1:0];
    assign RD_FERR   = rd_entry.ferr;
    assign RD_PERR   = rd_entry.perr;
    assign RD_BRK    = rd_entry.brk;
    // Data field is sized for the widest frame; narrower builds leave its top bits idle.
    assign unused_rd = ^rd_entry.data;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed + randomized bench for uart_rx_ovs (16 clk/bit, 8E1, 4-entry FIFO) against a
// frame-level reference model of the expected FIFO entries and overrun flag.
module tb_uart_rx_ovs;

    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int FRAME = 11;  // start + 8 data + parity + stop
    // sync+edge (3) + counter positions up to the completion sample + push cycle
    localparam int LAT   = 3 + (FRAME - 1) * CPB + (CPB / 2 + 2) + 1;

    logic          CLK = 1'b0;
    logic          RST_X = 1'b0;
    logic          RXD = 1'b1;
    logic          RD_READY = 1'b0;
    logic          OVR_CLR = 1'b0;
    logic [DB-1:0] RD_DATA;
    logic          RD_FERR, RD_PERR, RD_BRK, RD_VALID, OVERRUN;
    logic [2:0]    COUNT;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       brk;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q[$];
    logic ovr_m = 1'b0;

    always #5 CLK = ~CLK;

    uart_rx_ovs #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .PARITY       (1),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST_X    (RST_X),
        .RXD      (RXD),
        .RD_DATA  (RD_DATA),
        .RD_FERR  (RD_FERR),
        .RD_PERR  (RD_PERR),
        .RD_BRK   (RD_BRK),
        .RD_VALID (RD_VALID),
        .RD_READY (RD_READY),
        .COUNT    (COUNT),
        .OVERRUN  (OVERRUN),
        .OVR_CLR  (OVR_CLR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        RXD = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic model_push(input exp_t e);
        if (q.size() == DEPTH) ovr_m = 1'b1;
        else                   q.push_back(e);
    endtask

    task automatic check_head(input string tag);
        chk({tag, ".valid"}, RD_VALID, 1);
        if (q.size() > 0) begin
            chk({tag, ".data"}, RD_DATA, q[0].d);
            chk({tag, ".brk"},  RD_BRK,  q[0].brk);
            chk({tag, ".perr"}, RD_PERR, q[0].perr);
            chk({tag, ".ferr"}, RD_FERR, q[0].ferr);
        end
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            check_head(tag);
            void'(q.pop_front());
            RD_READY = 1'b1;
            @(negedge CLK);
            RD_READY = 1'b0;
        end
        chk({tag, ".empty_valid"}, RD_VALID, 0);
        chk({tag, ".empty_count"}, COUNT, 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".valid"},   RD_VALID, 0);
        chk({tag, ".count"},   COUNT, 0);
        chk({tag, ".overrun"}, OVERRUN, 0);
        chk({tag, ".data"},    RD_DATA, 0);
        chk({tag, ".tags"},    {RD_BRK, RD_PERR, RD_FERR}, 0);
    endtask

    // Drives one 8E1 frame cycle by cycle; gbit >= 0 inverts one mid-bit sample of that frame bit.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input int gbit, input bit chk_lat, input bit pop_done);
        logic [FRAME-1:0] bits;
        logic             p;
        exp_t             e;
        p    = (^d) ^ bad_par;
        bits = {~bad_stop, p, d, 1'b0};
        for (int k = 0; k < FRAME * CPB; k++) begin
            RXD = bits[k / CPB] ^ (k == gbit * CPB + CPB / 2 + 1);
            @(negedge CLK);
            if (chk_lat && k + 1 == LAT - 1) chk("latency_early", RD_VALID, 0);
            if (chk_lat && k + 1 == LAT)     chk("latency",       RD_VALID, 1);
            if (pop_done && k + 1 == LAT - 1) begin
                check_head("pop_on_push");
                void'(q.pop_front());
                RD_READY = 1'b1;
            end
            if (pop_done && k + 1 == LAT) RD_READY = 1'b0;
        end
        e.d    = d;
        e.brk  = (d == 8'h00) && !p && bad_stop;
        e.perr = bad_par && !e.brk;
        e.ferr = bad_stop;
        model_push(e);
    endtask

    initial begin
        logic [7:0] rd;
        bit         bp, bs;
        int         gb;

        repeat (3) @(negedge CLK);
        check_reset("reset");
        RST_X = 1'b1;
        idle(10);

        // clean frame with latency check
        send_frame(8'hA5, 0, 0, -1, 1, 0);
        chk("a5.count", COUNT, 1);
        drain("a5");

        // parity error, then framing error
        send_frame(8'h3C, 1, 0, -1, 0, 0);
        drain("perr");
        send_frame(8'h3C, 0, 1, -1, 0, 0);
        idle(CPB);
        drain("ferr");

        // short low glitch is a false start
        RXD = 1'b0;
        repeat (5) @(negedge CLK);
        idle(60);
        chk("glitch.count", COUNT, 0);
        chk("glitch.valid", RD_VALID, 0);

        // one inverted sample inside data bit 3 is outvoted
        send_frame(8'h5A, 0, 0, 4, 1, 0);
        drain("vote");

        // break: two frame times low
        RXD = 1'b0;
        repeat (2 * FRAME * CPB) @(negedge CLK);
        idle(40);
        model_push('{d: 8'h00, brk: 1'b1, perr: 1'b0, ferr: 1'b1});
        chk("brk.count", COUNT, 1);
        idle(200);
        chk("brk.count_hold", COUNT, 1);
        drain("brk");

        // five back-to-back frames into a 4-entry FIFO
        for (int i = 0; i < 5; i++) send_frame(8'(8'h11 * (i + 1)), 0, 0, -1, 0, 0);
        idle(4);
        chk("ovr.count", COUNT, q.size());
        chk("ovr.flag",  OVERRUN, ovr_m);
        OVR_CLR = 1'b1;
        @(negedge CLK);
        OVR_CLR = 1'b0;
        ovr_m   = 1'b0;
        chk("ovr.clear", OVERRUN, ovr_m);
        drain("ovr");

        // full FIFO popped on the completion push: frame 5 kept
        for (int i = 0; i < 4; i++) send_frame(8'(8'h21 + i), 0, 0, -1, 0, 0);
        send_frame(8'hE7, 0, 0, -1, 0, 1);
        idle(4);
        chk("fullpop.count",   COUNT, q.size());
        chk("fullpop.overrun", OVERRUN, ovr_m);
        drain("fullpop");

        // reset in the middle of a data field with an entry waiting
        send_frame(8'h77, 0, 0, -1, 0, 0);
        idle(5);
        RXD = 1'b0;
        repeat (CPB + 40) @(negedge CLK);
        RST_X = 1'b0;
        @(negedge CLK);
        check_reset("midreset");
        RXD = 1'b1;
        repeat (3) @(negedge CLK);
        RST_X = 1'b1;
        q.delete();
        ovr_m = 1'b0;
        idle(20);
        send_frame(8'hC3, 0, 0, -1, 1, 0);
        drain("post_reset");

        // randomized frames
        for (int i = 0; i < 12; i++) begin
            rd = 8'($urandom);
            if (i == 0) rd = 8'h00;
            bp = ($urandom_range(0, 3) == 0);
            bs = (i == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            gb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1;
            send_frame(rd, bp, bs, gb, 0, 0);
            idle((bs ? 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 2))) * CPB);
            drain("rand");
        end
        chk("final.overrun", OVERRUN, ovr_m);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ovs.md
# uart_rx_ovs

Parametrised UART receiver with majority-vote bit sampling, configurable frame format, per-character error tagging and a receive FIFO. It supersedes the fixed 8N1 deserializer on the serial input path: the program loader and the console/keyboard path consume characters through a valid/ready pop port instead of a one-cycle strobe, so back-to-back characters are no longer lost while the consumer is busy.

## Interface
- `CLKS_PER_BIT`, 50: CLK cycles per bit (f/b); ≥ 8.
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first.
- `PARITY`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: entries, power of 2, ≥ 2.
- `CLK`  in  1  core clock.
- `RST_X`  in  1  reset, asynchronous, active-low.
- `RXD`  in  1  serial line, asynchronous, idle high.
- `RD_DATA`  out  DATA_BITS  head-entry data.
- `RD_FERR` / `RD_PERR` / `RD_BRK`  out  1 each  head-entry framing / parity / break tags.
- `RD_VALID`  out  1  FIFO non-empty.
- `RD_READY`  in  1  pop head when `RD_VALID`.
- `COUNT`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `OVERRUN`  out  1  sticky: a frame was dropped on full FIFO.
- `OVR_CLR`  in  1  clears `OVERRUN`.

## Operation
- `RXD` passes a 2-flop synchroniser (forced high at reset); all logic uses the synchronised `rxs`.
- Bit value = majority of `rxs` at counter positions H-1, H, H+1, where H = CLKS_PER_BIT/2 (integer); counter runs 0..CLKS_PER_BIT-1 per bit, then wraps.
- FSM states: IDLE, START, DATA, PAR, STOP, BRKWAIT.
- IDLE: falling edge of `rxs` → START, counter = 0.
- START: at H+1, a voted 1 is a false start → IDLE with no entry; a voted 0 continues; at the counter wrap → DATA.
- DATA: shifts DATA_BITS voted bits LSB-first. Then → PAR if PARITY≠0, else → STOP.
- PAR: voted bit is checked against the XOR of the data bits (even) or its inverse (odd); a mismatch sets perr.
- STOP: samples STOP_BITS bits; any voted 0 sets ferr. The frame completes at H+1 of the last stop bit (no wait for the bit end), which gives early re-sync.
- Break: data all 0, parity bit 0 if present, and first stop bit 0 → brk=1, ferr=1, perr=0. The entry is pushed, then → BRKWAIT. BRKWAIT leaves for IDLE only after `rxs` = 1.
- Otherwise completion → IDLE. The entry {brk, perr, ferr, data} is pushed.
- Push when full with no pop that cycle: entry dropped, `OVERRUN` ← 1. Push and pop in the same cycle while full: push accepted and COUNT unchanged.
- If `OVR_CLR` and a new overrun occur in the same cycle, set wins.
- FIFO: registered output, no fall-through. Pointers are $clog2(FIFO_DEPTH) bits plus a wrap bit. COUNT = wptr - rptr.

## Timing
- Reset (async assert, sync release) values:
  - FSM = IDLE, pointers = 0, COUNT = 0.
  - `RD_VALID` = 0, `RD_DATA`/tags = 0, `OVERRUN` = 0.
  - Synchroniser = 1.
- Reset mid-frame discards the partial frame and all FIFO contents.
- Latency: the push occurs on the cycle after the completion sample. `RD_VALID` rises the cycle after the push. End-to-end, from the `RXD` falling edge, it is 2 (sync) + 1 (edge) + frame samples + 2 cycles.
- Pop: `RD_VALID && RD_READY` at an edge advances rptr. The next entry appears on the following cycle, so sustained 1 pop/cycle is possible.
- The FSM accepts a new start edge on the cycle after completion. Continuous back-to-back frames are received with no gap.

## Structure
- Package `uart_pkg`:
  - Parity constants `PAR_NONE` / `PAR_EVEN` / `PAR_ODD`.
  - FSM state typedef.
  - `rx_entry_t` struct {brk, perr, ferr, data}.
  - Shared with the planned parametrised transmitter.
- Sub-module `uart_sync_fifo` (WIDTH, DEPTH): push/pop/full/empty/count. It is reusable for a TX FIFO.
- The top holds the synchroniser, bit counter, voter and FSM.

## Test plan
All cases use CLKS_PER_BIT=16, DATA_BITS=8, PARITY=1 (even), STOP_BITS=1, FIFO_DEPTH=4 unless noted.

- Send 0xA5 with correct parity → one entry {0,0,0,0xA5}, `COUNT`=1, `RD_VALID` at the stated latency.
- 0x3C with wrong parity → entry perr=1. Stop held low on 0x3C → ferr=1. Both still pushed.
- A 5-cycle low glitch on `RXD` → no entry and FSM back in IDLE. A single-cycle inverted sample at H inside a data bit → data correct (vote).
- Line low for 2 frame times, then high → one entry brk=1, ferr=1, data=0x00. No further entries until the next start.
- 5 back-to-back frames with `RD_READY`=0 → `COUNT`=4, `OVERRUN`=1, entries 1-4 retained in order. `OVR_CLR` → 0.
- FIFO full, `RD_READY`=1 held on the completion cycle of frame 5 → frame 5 accepted, no overrun. Also: reset asserted mid-DATA → all outputs at reset values, and the next clean frame is received normally.
